// File: rtl/alu_op_sched.sv
// Sequencing controller for the plus/and/or/xor op-cell bank: takes a command,
// streams operands into the selected cell, drains its result and hands it downstream.
module alu_op_sched #(
  parameter int COUNT_W = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [1:0]         i_cmd_op,
  input  logic [COUNT_W-1:0] i_cmd_count,
  input  logic               i_operand_valid,
  output logic               o_operand_ready,
  input  logic [31:0]        i_operand,
  output logic [3:0]         o_cell_data_valid,
  output logic [31:0]        o_cell_data,
  input  logic [3:0]         i_cell_result_valid,
  input  logic [127:0]       i_cell_result,
  output logic [3:0]         o_cell_result_ready,
  output logic               o_result_valid,
  input  logic               i_result_ready,
  output logic [31:0]        o_result,
  output logic [1:0]         o_result_op,
  output logic               o_result_err,
  output logic               o_cmd_err
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0]  TIMEOUT_C = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0]  WAIT_ONE_C = WAIT_W'(1);
  localparam logic [COUNT_W-1:0] CNT_ONE_C = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] CNT_ZERO_C = {COUNT_W{1'b0}};

  typedef enum logic [2:0] {
    FLUSH = 3'd0,
    IDLE  = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

  state_t             state_r;
  state_t             next_state_s;
  logic [1:0]         op_r;
  logic [COUNT_W-1:0] count_r;
  logic [COUNT_W-1:0] fed_r;
  logic [WAIT_W-1:0]  wait_r;
  logic [31:0]        result_r;
  logic [1:0]         result_op_r;
  logic               result_err_r;
  logic               result_valid_r;
  logic               cmd_err_r;

  logic               cmd_ok_s;
  logic               last_op_s;
  logic               res_hit_s;
  logic               timeout_s;
  logic               cmd_ready_s;
  logic               operand_ready_s;
  logic [3:0]         cell_data_valid_s;
  logic [3:0]         cell_result_ready_s;

  assign cmd_ok_s  = i_cmd_valid && (i_cmd_count != CNT_ZERO_C);
  assign last_op_s = i_operand_valid && ((fed_r + CNT_ONE_C) == count_r);
  assign res_hit_s = i_cell_result_valid[op_r];
  assign timeout_s = (wait_r == TIMEOUT_C);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= FLUSH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      FLUSH: next_state_s = IDLE;
      IDLE: begin
        if (cmd_ok_s) next_state_s = FEED;
        else          next_state_s = IDLE;
      end
      FEED: begin
        if (last_op_s) next_state_s = DRAIN;
        else           next_state_s = FEED;
      end
      DRAIN: begin
        if (res_hit_s || timeout_s) next_state_s = OUT;
        else                        next_state_s = DRAIN;
      end
      OUT: begin
        if (i_result_ready) next_state_s = IDLE;
        else                next_state_s = OUT;
      end
      default: next_state_s = FLUSH;
    endcase
  end

  // Cell and handshake strobes; on timeout the selected cell is still emptied
  always_comb begin
    cmd_ready_s         = 1'b0;
    operand_ready_s     = 1'b0;
    cell_data_valid_s   = 4'h0;
    cell_result_ready_s = 4'h0;
    case (state_r)
      FLUSH: cell_result_ready_s = 4'hF;
      IDLE:  cmd_ready_s = 1'b1;
      FEED: begin
        operand_ready_s   = 1'b1;
        cell_data_valid_s = onehot4(op_r) & {4{i_operand_valid}};
      end
      DRAIN: begin
        if (res_hit_s || timeout_s) cell_result_ready_s = onehot4(op_r);
        else                        cell_result_ready_s = 4'h0;
      end
      OUT:     cmd_ready_s = 1'b0;
      default: cmd_ready_s = 1'b0;
    endcase
  end

  // Command latch, counters and registered result outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      op_r           <= 2'd0;
      count_r        <= CNT_ZERO_C;
      fed_r          <= CNT_ZERO_C;
      wait_r         <= {WAIT_W{1'b0}};
      result_r       <= 32'h0;
      result_op_r    <= 2'd0;
      result_err_r   <= 1'b0;
      result_valid_r <= 1'b0;
      cmd_err_r      <= 1'b0;
    end else begin
      cmd_err_r      <= 1'b0;
      result_valid_r <= (next_state_s == OUT);
      case (state_r)
        IDLE: begin
          cmd_err_r <= i_cmd_valid && (i_cmd_count == CNT_ZERO_C);
          if (cmd_ok_s) begin
            op_r    <= i_cmd_op;
            count_r <= i_cmd_count;
            fed_r   <= CNT_ZERO_C;
          end
        end
        FEED: begin
          wait_r <= {WAIT_W{1'b0}};
          if (i_operand_valid) fed_r <= fed_r + CNT_ONE_C;
        end
        DRAIN: begin
          if (res_hit_s) begin
            result_r     <= i_cell_result[{op_r, 5'd0} +: 32];
            result_op_r  <= op_r;
            result_err_r <= 1'b0;
          end else if (timeout_s) begin
            result_r     <= 32'h0;
            result_op_r  <= op_r;
            result_err_r <= 1'b1;
          end else begin
            wait_r <= wait_r + WAIT_ONE_C;
          end
        end
        default: wait_r <= wait_r;
      endcase
    end
  end

  assign o_cmd_ready         = cmd_ready_s;
  assign o_operand_ready     = operand_ready_s;
  assign o_cell_data_valid   = cell_data_valid_s;
  assign o_cell_data         = i_operand;
  assign o_cell_result_ready = cell_result_ready_s;
  assign o_result_valid      = result_valid_r;
  assign o_result            = result_r;
  assign o_result_op         = result_op_r;
  assign o_result_err        = result_err_r;
  assign o_cmd_err           = cmd_err_r;

endmodule

// File: tb/tb_alu_op_sched.sv
// Scoreboard bench for alu_op_sched with behavioural op-cells that power up
// holding garbage partial results.
module tb_alu_op_sched;
  localparam int COUNT_W = 8;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic        err;
    logic [1:0]  op;
    logic [31:0] res;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'd0;
  logic [COUNT_W-1:0] cmd_count = 8'd0;
  logic               operand_valid = 1'b0;
  logic               operand_ready;
  logic [31:0]        operand = 32'h0;
  logic [3:0]         cell_data_valid;
  logic [31:0]        cell_data;
  logic [3:0]         cell_result_valid;
  logic [127:0]       cell_result;
  logic [3:0]         cell_result_ready;
  logic               result_valid;
  logic               result_ready = 1'b0;
  logic [31:0]        result;
  logic [1:0]         result_op;
  logic               result_err;
  logic               cmd_err;

  int n_cmp = 0;
  int n_err = 0;
  int last_wait = 0;
  int bad_dv = 0;
  int rr_cnt [4] = '{0, 0, 0, 0};
  logic [3:0] cur_mask = 4'h0;
  logic [3:0] stub = 4'h0;
  exp_t sb_q [$];

  logic [3:0]  cell_empty = 4'h0;
  logic [31:0] cell_acc [4] = '{32'hDEAD0001, 32'hBEEF0F0F, 32'h00C0FFEE, 32'h5A5A5A5A};

  always #5 clk = ~clk;

  alu_op_sched #(.COUNT_W(COUNT_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op), .i_cmd_count(cmd_count),
    .i_operand_valid(operand_valid), .o_operand_ready(operand_ready), .i_operand(operand),
    .o_cell_data_valid(cell_data_valid), .o_cell_data(cell_data),
    .i_cell_result_valid(cell_result_valid), .i_cell_result(cell_result),
    .o_cell_result_ready(cell_result_ready),
    .o_result_valid(result_valid), .i_result_ready(result_ready), .o_result(result),
    .o_result_op(result_op), .o_result_err(result_err), .o_cmd_err(cmd_err)
  );

  function automatic logic [31:0] apply(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a & b;
      2'd2:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Behavioural cells: first operand loads, later ones combine; result_ready empties
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (cell_data_valid[k]) begin
        cell_acc[k]   <= cell_empty[k] ? cell_data : apply(2'(k), cell_acc[k], cell_data);
        cell_empty[k] <= 1'b0;
      end else if (cell_result_ready[k]) begin
        cell_empty[k] <= 1'b1;
      end
    end
  end
  assign cell_result_valid = ~cell_empty & ~stub;
  assign cell_result = {cell_acc[3], cell_acc[2], cell_acc[1], cell_acc[0]};

  // Strobe monitor
  always @(negedge clk) begin
    if (|(cell_data_valid & ~cur_mask)) bad_dv <= bad_dv + 1;
    for (int k = 0; k < 4; k++) begin
      if (cell_result_ready[k]) rr_cnt[k] <= rr_cnt[k] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input int n);
    int t;
    cmd_valid = 1'b1; cmd_op = op; cmd_count = COUNT_W'(n);
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin t++; @(negedge clk); end
    check_eq("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_operand(input logic [31:0] v, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    operand_valid = 1'b1; operand = v;
    t = 0;
    @(negedge clk);
    while (!operand_ready && t < 50) begin t++; @(negedge clk); end
    check_eq("opnd_accept", 32'(operand_ready), 32'd1);
    @(posedge clk); #1;
    operand_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int waited;
    waited = 0;
    @(negedge clk);
    while (!result_valid && waited < 200) begin waited++; @(negedge clk); end
    last_wait = waited;
    check_eq("result_valid", 32'(result_valid), 32'd1);
    check_eq("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("result", result, e.res);
      check_eq("result_op", 32'(result_op), 32'(e.op));
      check_eq("result_err", 32'(result_err), 32'(e.err));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check_eq("hold_valid", 32'(result_valid), 32'd1);
        check_eq("hold_result", result, e.res);
      end
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    @(negedge clk);
    check_eq("valid_fall", 32'(result_valid), 32'd0);
    check_eq("ready_after", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [1:0] op, input int n, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] c, input int gap, input int hold, input logic do_stub);
    logic [31:0] v [3];
    exp_t e;
    v = '{a, b, c};
    e.res = v[0];
    for (int i = 1; i < n; i++) e.res = apply(op, e.res, v[i]);
    e.op = op;
    e.err = do_stub;
    if (do_stub) e.res = 32'h0;
    cur_mask = 4'b0001 << op;
    stub = do_stub ? cur_mask : 4'h0;
    sb_q.push_back(e);
    send_cmd(op, n);
    for (int i = 0; i < n; i++) send_operand(v[i], (i == 0) ? 0 : gap);
    collect(hold);
    stub = 4'h0;
  endtask

  task automatic reset_seq();
    rst_n = 1'b0; cmd_valid = 1'b0; operand_valid = 1'b0; result_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_valid", 32'(result_valid), 32'd0);
    check_eq("rst_result", result, 32'h0);
    check_eq("rst_errs", {29'd0, result_op, result_err | cmd_err}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("flush_rr", 32'(cell_result_ready), 32'hF);
    check_eq("flush_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check_eq("idle_rr", 32'(cell_result_ready), 32'h0);
    check_eq("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int rr0;
    // 1: garbage-loaded cells must be flushed before the first plus
    reset_seq();
    run(2'd0, 2, 32'h1B, 32'h0E, 32'h0, 0, 0, 1'b0);
    check_eq("ideal_latency", 32'(last_wait), 32'd1);

    // 2: and/or/xor over the same operands
    for (int op = 1; op < 4; op++) run(2'(op), 3, 32'h3F, 32'h38, 32'h18, 0, 1, 1'b0);

    // 3: gapped operands and a stalled consumer
    run(2'd0, 2, 32'h1B, 32'h0E, 32'h0, 3, 5, 1'b0);

    // 4: zero-count command is discarded with a one-cycle error pulse
    cur_mask = 4'h0;
    send_cmd(2'd2, 0);
    @(negedge clk);
    check_eq("cmd_err_pulse", 32'(cmd_err), 32'd1);
    check_eq("cmd_err_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    check_eq("cmd_err_clear", 32'(cmd_err), 32'd0);
    check_eq("cmd_err_ready2", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;

    // 5: silent cell times out with exactly one result_ready pulse
    rr0 = rr_cnt[1];
    run(2'd1, 2, 32'hF0, 32'h3C, 32'h0, 0, 2, 1'b1);
    check_eq("timeout_latency", 32'(last_wait), 32'(TIMEOUT + 1));
    check_eq("timeout_rr_pulses", 32'(rr_cnt[1] - rr0), 32'd1);

    // 6: reset mid-FEED aborts, then a fresh command works
    cur_mask = 4'b0001;
    send_cmd(2'd0, 3);
    send_operand(32'h7, 0);
    reset_seq();
    run(2'd0, 1, 32'h05, 32'h0, 32'h0, 0, 0, 1'b0);

    check_eq("foreign_data_valid", 32'(bad_dv), 32'd0);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
